// File: rtl/simon_key_expander_pkg.sv
// Shared definitions for the SIMON key schedule: the five z constant
// sequences, the controller state encoding and the parameter legality check.
package simon_key_expander_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int Z_LEN = 62;

    // Sequences are written first-bit-leftmost below; this flips them so the
    // first sequence bit lands at index 0.
    function automatic logic [Z_LEN-1:0] first_bit_at_lsb(input logic [Z_LEN-1:0] s);
        logic [Z_LEN-1:0] r;
        for (int i = 0; i < Z_LEN; i++) begin
            r[i] = s[Z_LEN-1-i];
        end
        return r;
    endfunction

    // Z_SEQ[s][j] is bit j of sequence z<s>.
    localparam logic [4:0][Z_LEN-1:0] Z_SEQ = {
        first_bit_at_lsb(62'b11010001111001101011011000100000010111000011001010010011101111),
        first_bit_at_lsb(62'b11011011101011000110010111100000010010001010011100110100001111),
        first_bit_at_lsb(62'b10101111011100000011010010011000101000010001111110010110110011),
        first_bit_at_lsb(62'b10001110111110010011000010110101000111011111001001100001011010),
        first_bit_at_lsb(62'b11111010001001010110000111001101111101000100101011000011100110)
    };

    // True when the word width, key word count, z select and round-key count
    // form a configuration the expander can build.
    function automatic bit params_legal(input int n, input int m, input int z_sel, input int t);
        bit n_ok;
        n_ok = (n == 16) || (n == 24) || (n == 32) || (n == 48) || (n == 64);
        return n_ok && (m >= 2) && (m <= 4) && (z_sel >= 0) && (z_sel <= 4) &&
               (t >= m) && (t <= 127);
    endfunction

endpackage

// File: rtl/simon_key_expander_if.sv
// Request / round-key stream bundle between a key consumer and the expander.
interface simon_key_expander_if #(
    parameter int N = 48,
    parameter int M = 2
);
    logic           start;
    logic [N*M-1:0] key;
    logic           busy;
    logic           rk_valid;
    logic           rk_ready;
    logic [N-1:0]   rk_data;
    logic [6:0]     rk_idx;
    logic           done;

    modport master (
        output start, key, rk_ready,
        input  busy, rk_valid, rk_data, rk_idx, done
    );

    modport slave (
        input  start, key, rk_ready,
        output busy, rk_valid, rk_data, rk_idx, done
    );
endinterface

// File: rtl/simon_key_round.sv
// Combinational SIMON key-schedule step: derives the next key word from the
// current M-word window and the active z bit.
module simon_key_round #(
    parameter int N = 48,
    parameter int M = 2
) (
    input  logic [M-1:0][N-1:0] window,
    input  logic                z_bit,
    output logic [N-1:0]        new_word
);
    logic [N-1:0] tmp_ror3;
    logic [N-1:0] tmp_mix;
    logic [N-1:0] tmp_full;
    logic         unused_window;

    // Not every window word feeds the step for every M; fold them here.
    assign unused_window = ^window;

    // Rotate the newest word, mix in w[1] for four-word keys, fold in its
    // own rotation, then combine with the oldest word and the constants.
    always_comb begin
        tmp_ror3 = {window[M-1][2:0], window[M-1][N-1:3]};
        tmp_mix  = tmp_ror3;
        if (M == 4) begin
            tmp_mix = tmp_ror3 ^ window[1];
        end
        tmp_full = tmp_mix ^ {tmp_mix[0], tmp_mix[N-1:1]};
        new_word = ~window[0] ^ tmp_full ^ {{(N-1){1'b0}}, z_bit} ^ N'(3);
    end

endmodule

// File: rtl/simon_key_expander.sv
// SIMON key expander: loads an M-word master key and streams T round keys
// over a valid/ready handshake, one per cycle when the consumer is ready.
module simon_key_expander #(
    parameter int N     = 48,
    parameter int M     = 2,
    parameter int Z_SEL = 2,
    parameter int T     = 52
) (
    input  logic                 clk,
    input  logic                 rst_n,
    simon_key_expander_if.slave  bus
);
    import simon_key_expander_pkg::*;

    if (!params_legal(N, M, Z_SEL, T)) begin : g_bad_params
        $error("simon_key_expander: illegal N/M/Z_SEL/T combination");
    end

    localparam logic [Z_LEN-1:0] Z_ACTIVE = Z_SEQ[Z_SEL];

    state_t              state;
    state_t              state_next;
    logic [M-1:0][N-1:0] window;
    logic [6:0]          idx;
    logic [5:0]          z_cnt;
    logic                load;
    logic                advance;
    logic                last_key;
    logic                z_bit;
    logic [N-1:0]        new_word;

    assign last_key = (idx == 7'(T - 1));
    assign z_bit    = Z_ACTIVE[z_cnt];

    simon_key_round #(
        .N (N),
        .M (M)
    ) u_round (
        .window   (window),
        .z_bit    (z_bit),
        .new_word (new_word)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, window load/advance strobes and status outputs; the last
    // handshake only moves to DONE and leaves the window untouched.
    always_comb begin
        state_next   = state;
        load         = 1'b0;
        advance      = 1'b0;
        bus.busy     = (state != ST_IDLE);
        bus.rk_valid = (state == ST_RUN);
        bus.done     = (state == ST_DONE);
        bus.rk_data  = window[0];
        bus.rk_idx   = idx;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_RUN;
                    load       = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.rk_ready) begin
                    if (last_key) begin
                        state_next = ST_DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Key window, round-key index and z position: loaded from the master key
    // on start, shifted by one word per accepted key.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            window <= '0;
            idx    <= '0;
            z_cnt  <= '0;
        end else if (load) begin
            window <= bus.key;
            idx    <= '0;
            z_cnt  <= '0;
        end else if (advance) begin
            for (int i = 0; i < M - 1; i++) begin
                window[i] <= window[i+1];
            end
            window[M-1] <= new_word;
            idx         <= idx + 7'd1;
            z_cnt       <= (z_cnt == 6'd61) ? 6'd0 : z_cnt + 6'd1;
        end
    end

endmodule

// File: tb/tb_simon_key_expander.sv
// Testbench for simon_key_expander: three configurations share one stimulus
// path; a reference key schedule fills a scoreboard that the output stream
// is checked against.
module tb_simon_key_expander;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    simon_key_expander_if #(.N(16), .M(4)) ifa ();
    simon_key_expander_if #(.N(48), .M(2)) ifb ();
    simon_key_expander_if #(.N(48), .M(2)) ifc ();

    simon_key_expander #(.N(16), .M(4), .Z_SEL(0), .T(32)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (ifa));
    simon_key_expander #(.N(48), .M(2), .Z_SEL(2), .T(127)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (ifb));
    simon_key_expander #(.N(48), .M(2), .Z_SEL(2), .T(52)) dut_c (
        .clk (clk), .rst_n (rst_n), .bus (ifc));

    int          sel;
    logic        start;
    logic        rk_ready;
    logic [95:0] key;

    assign ifa.start    = start && (sel == 0);
    assign ifb.start    = start && (sel == 1);
    assign ifc.start    = start && (sel == 2);
    assign ifa.key      = key[63:0];
    assign ifb.key      = key;
    assign ifc.key      = key;
    assign ifa.rk_ready = rk_ready;
    assign ifb.rk_ready = rk_ready;
    assign ifc.rk_ready = rk_ready;

    logic        cur_valid;
    logic        cur_busy;
    logic        cur_done;
    logic [63:0] cur_data;
    logic [6:0]  cur_idx;

    // Route the selected instance's outputs onto common observation signals.
    always_comb begin
        case (sel)
            0: begin
                cur_valid = ifa.rk_valid;
                cur_busy  = ifa.busy;
                cur_done  = ifa.done;
                cur_data  = {48'd0, ifa.rk_data};
                cur_idx   = ifa.rk_idx;
            end
            1: begin
                cur_valid = ifb.rk_valid;
                cur_busy  = ifb.busy;
                cur_done  = ifb.done;
                cur_data  = {16'd0, ifb.rk_data};
                cur_idx   = ifb.rk_idx;
            end
            default: begin
                cur_valid = ifc.rk_valid;
                cur_busy  = ifc.busy;
                cur_done  = ifc.done;
                cur_data  = {16'd0, ifc.rk_data};
                cur_idx   = ifc.rk_idx;
            end
        endcase
    end

    int cfg_n [3] = '{16, 48, 48};
    int cfg_m [3] = '{4, 2, 2};
    int cfg_z [3] = '{0, 2, 2};
    int cfg_t [3] = '{32, 127, 52};

    string z_tab [5] = '{
        "11111010001001010110000111001101111101000100101011000011100110",
        "10001110111110010011000010110101000111011111001001100001011010",
        "10101111011100000011010010011000101000010001111110010110110011",
        "11011011101011000110010111100000010010001010011100110100001111",
        "11010001111001101011011000100000010111000011001010010011101111"
    };

    typedef struct packed {
        logic [6:0]  idx;
        logic [63:0] data;
    } sb_entry_t;

    sb_entry_t   sb [$];
    logic [63:0] gold [128];
    int          n_compared;
    int          n_mismatched;

    typedef struct {
        int          dut_sel;
        logic [95:0] key;
        int          ready_mode;
        logic [63:0] exp_k0;
    } vec_t;

    vec_t        vecs [5];
    logic [63:0] ref4 [4];

    function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
        logic [63:0] mask;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        return ((x >> r) | (x << (n - r))) & mask;
    endfunction

    task automatic build_model(input int s, input logic [95:0] k);
        int          n;
        int          m;
        logic [63:0] mask;
        logic [63:0] tmp;
        logic [63:0] z;
        n    = cfg_n[s];
        m    = cfg_m[s];
        mask = (64'd1 << n) - 64'd1;
        for (int i = 0; i < m; i++) begin
            gold[i] = 64'(k >> (n * i)) & mask;
        end
        for (int i = m; i < cfg_t[s]; i++) begin
            tmp = ror(gold[i-1], 3, n);
            if (m == 4) tmp = tmp ^ gold[i-3];
            tmp = tmp ^ ror(tmp, 1, n);
            z = (z_tab[cfg_z[s]][(i - m) % 62] == 8'h31) ? 64'd1 : 64'd0;
            gold[i] = (~gold[i-m] ^ tmp ^ z ^ 64'd3) & mask;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=%h required=%h (sel=%0d t=%0t)",
                     name, actual, expected, sel, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load the expected stream into the scoreboard, then request expansion.
    task automatic applyStimulus(input logic [95:0] k, input bit hold_start);
        sb_entry_t e;
        key = k;
        build_model(sel, k);
        for (int i = 0; i < cfg_t[sel]; i++) begin
            e.idx  = 7'(i);
            e.data = gold[i];
            sb.push_back(e);
        end
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        checkOutput("first_valid", 64'(cur_valid), 64'd1);
        checkOutput("first_busy", 64'(cur_busy), 64'd1);
        checkOutput("first_idx", 64'(cur_idx), 64'd0);
    endtask

    // Drain the stream against the scoreboard; optional start injection,
    // reset abort at a given index, or a 20-cycle stall on the last key.
    task automatic consume(input int ready_mode, input int inject_at,
                           input int abort_idx, input bit stall_last);
        int        cycles;
        int        stall;
        bit        stalled_once;
        bit        finished;
        int        t;
        sb_entry_t exp_e;
        cycles       = 0;
        stall        = 0;
        stalled_once = 1'b0;
        finished     = 1'b0;
        t            = cfg_t[sel];
        while (!finished) begin
            if (cycles > 3000 || sb.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL stream_timeout: actual=%0d cycles required=<=3000 sb=%0d",
                         cycles, sb.size());
                sb.delete();
                start    = 1'b0;
                rk_ready = 1'b0;
                return;
            end
            exp_e = sb[0];
            checkOutput("rk_valid", 64'(cur_valid), 64'd1);
            checkOutput("rk_idx", 64'(cur_idx), 64'(exp_e.idx));
            checkOutput("rk_data", cur_data, exp_e.data);
            checkOutput("done_low", 64'(cur_done), 64'd0);
            if (abort_idx >= 0 && int'(exp_e.idx) == abort_idx) begin
                rst_n    = 1'b0;
                rk_ready = 1'b1;
                tick();
                checkOutput("rst_valid", 64'(cur_valid), 64'd0);
                checkOutput("rst_busy", 64'(cur_busy), 64'd0);
                checkOutput("rst_done", 64'(cur_done), 64'd0);
                checkOutput("rst_idx", 64'(cur_idx), 64'd0);
                checkOutput("rst_data", cur_data, 64'd0);
                rst_n    = 1'b1;
                rk_ready = 1'b0;
                tick();
                checkOutput("post_rst_done", 64'(cur_done), 64'd0);
                checkOutput("post_rst_busy", 64'(cur_busy), 64'd0);
                sb.delete();
                return;
            end
            if (stall_last && !stalled_once && int'(exp_e.idx) == t - 1) begin
                stall        = 20;
                stalled_once = 1'b1;
            end
            if (stall > 0) begin
                rk_ready = 1'b0;
                stall--;
            end else if (ready_mode == 0) begin
                rk_ready = 1'b1;
            end else begin
                rk_ready = 1'($urandom_range(0, 1));
            end
            if (cycles == inject_at) begin
                start = 1'b1;
                key   = {$urandom(), $urandom(), $urandom()};
            end else if (inject_at >= 0) begin
                start = 1'b0;
            end
            tick();
            cycles++;
            if (rk_ready) begin
                void'(sb.pop_front());
                if (int'(exp_e.idx) == t - 1) finished = 1'b1;
            end
        end
        rk_ready = 1'b0;
        if (inject_at >= 0) start = 1'b0;
        checkOutput("done_pulse", 64'(cur_done), 64'd1);
        checkOutput("done_busy", 64'(cur_busy), 64'd1);
        checkOutput("done_valid", 64'(cur_valid), 64'd0);
        tick();
        checkOutput("done_clear", 64'(cur_done), 64'd0);
        checkOutput("idle_busy", 64'(cur_busy), 64'd0);
        checkOutput("idle_valid", 64'(cur_valid), 64'd0);
    endtask

    // Bound on total run time.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        sel          = 0;
        start        = 1'b0;
        rk_ready     = 1'b0;
        key          = '0;
        rst_n        = 1'b0;
        n_compared   = 0;
        n_mismatched = 0;

        vecs[0] = '{0, 96'h1918_1110_0908_0100, 0, 64'h0100};
        vecs[1] = '{0, 96'hFFFF_0000_AAAA_5555, 1, 64'h5555};
        vecs[2] = '{2, 96'h0D0C0B0A0908_050403020100, 1, 64'h0000_0504_0302_0100};
        vecs[3] = '{1, 96'h123456789ABC_DEF012345678, 1, 64'h0000_DEF0_1234_5678};
        vecs[4] = '{1, 96'hFFFFFFFFFFFF_000000000000, 0, 64'h0};
        ref4    = '{64'h0100, 64'h0908, 64'h1110, 64'h1918};

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkOutput("reset_valid", 64'(cur_valid), 64'd0);
            checkOutput("reset_busy", 64'(cur_busy), 64'd0);
            checkOutput("reset_done", 64'(cur_done), 64'd0);
            checkOutput("reset_idx", 64'(cur_idx), 64'd0);
            checkOutput("reset_data", cur_data, 64'd0);
        end
        rst_n = 1'b1;
        tick();

        $display("[TB] table vectors");
        for (int v = 0; v < 5; v++) begin
            sel = vecs[v].dut_sel;
            applyStimulus(vecs[v].key, 1'b0);
            checkOutput("vec_k0", cur_data, vecs[v].exp_k0);
            consume(vecs[v].ready_mode, -1, -1, 1'b0);
        end

        $display("[TB] consecutive first keys, ready held high");
        sel = 0;
        applyStimulus(96'h1918_1110_0908_0100, 1'b0);
        for (int j = 0; j < 4; j++) begin
            checkOutput("k_consec", cur_data, ref4[j]);
            rk_ready = 1'b1;
            tick();
            void'(sb.pop_front());
        end
        consume(0, -1, -1, 1'b0);

        $display("[TB] random keys with random ready");
        for (int r = 0; r < 3; r++) begin
            sel = (r == 2) ? 2 : 1;
            applyStimulus({$urandom(), $urandom(), $urandom()}, 1'b0);
            consume(1, -1, -1, 1'b0);
        end

        $display("[TB] start pulsed while running");
        sel = 1;
        applyStimulus({$urandom(), $urandom(), $urandom()}, 1'b0);
        consume(1, 5, -1, 1'b0);

        $display("[TB] reset at index 10");
        sel = 0;
        applyStimulus(96'h0123_4567_89AB_CDEF, 1'b0);
        consume(0, -1, 10, 1'b0);
        applyStimulus(96'h7777_6666_5555_4444, 1'b0);
        checkOutput("restart_k0", cur_data, 64'h4444);
        consume(0, -1, -1, 1'b0);

        $display("[TB] stall on last key");
        sel = 0;
        applyStimulus(96'hDEAD_BEEF_CAFE_F00D, 1'b0);
        consume(0, -1, -1, 1'b1);

        $display("[TB] back-to-back with start held");
        sel = 0;
        applyStimulus(96'h1918_1110_0908_0100, 1'b1);
        consume(0, -1, -1, 1'b0);
        applyStimulus(96'h1918_1110_0908_0100, 1'b0);
        checkOutput("b2b_k0", cur_data, 64'h0100);
        consume(0, -1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
